bus_arb4: RTL and testbench

//  Four-master arbiter for the shared 32-bit addr/data/cmd bus used by the video controller and its peers.

---
 rtl/bus_arb4.sv | 170 +++++++++++++++++
 tb/tb_bus_arb4.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb4
//  Description : Four-master arbiter for the shared addr/data/cmd bus.
//                Priority first, then round-robin within the winning level;
//                holds the grant for a whole burst tenure and revokes it
//                through a watchdog when the owner stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arb4 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] len,
    input  logic [2:0] bus_cmd,
    output logic [3:0] ack,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    localparam int c_WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT - 1);

    localparam logic [2:0] c_CMD_WR_DATA = 3'b001;
    localparam logic [2:0] c_CMD_RD_REQ  = 3'b010;
    localparam logic [2:0] c_CMD_RD_DATA = 3'b011;
    localparam logic [2:0] c_CMD_WR_REQ  = 3'b100;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_TURN  = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_ack;
    logic [1:0]        r_grant_id;
    logic              r_timeout;
    logic [1:0]        r_rr_ptr;
    logic [3:0]        r_beats;
    logic [3:0]        r_beat_cnt;
    logic [c_WD_W-1:0] r_wd_cnt;

    logic [1:0] w_prio [4];
    logic [1:0] w_pmax;
    logic [1:0] w_idx;
    logic [1:0] w_win;
    logic       w_found;
    logic [1:0] w_len_sel;
    logic [3:0] w_win_beats;
    logic       w_is_addr;
    logic       w_is_beat;
    logic       w_wd_expired;
    logic       w_last_beat;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_prio
            assign w_prio[gi] = req[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        w_pmax = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_prio[i] > w_pmax) begin
                w_pmax = w_prio[i];
            end
        end
    end

    // Scan from the round-robin pointer, wrapping 3->0, for the first master
    // sitting at the highest requested priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && (w_pmax != 2'd0) && (w_prio[w_idx] == w_pmax)) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_len_sel    = len[2*w_win +: 2];
    assign w_win_beats  = 4'b0001 << w_len_sel;
    assign w_is_addr    = (bus_cmd == c_CMD_RD_REQ) || (bus_cmd == c_CMD_WR_REQ);
    assign w_is_beat    = (bus_cmd == c_CMD_WR_DATA) || (bus_cmd == c_CMD_RD_DATA);
    assign w_wd_expired = (r_wd_cnt == c_WD_MAX);
    assign w_last_beat  = (r_beat_cnt == (r_beats - 4'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_ack      <= 4'd0;
            r_grant_id <= 2'd0;
            r_timeout  <= 1'b0;
            r_rr_ptr   <= 2'd0;
            r_beats    <= 4'd1;
            r_beat_cnt <= 4'd0;
            r_wd_cnt   <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_ack      <= 4'b0001 << w_win;
                        r_grant_id <= w_win;
                        r_beats    <= w_win_beats;
                        r_rr_ptr   <= w_win + 2'd1;
                        r_beat_cnt <= 4'd0;
                        r_wd_cnt   <= '0;
                        r_state    <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    if (w_is_addr) begin
                        r_beat_cnt <= 4'd0;
                        r_wd_cnt   <= '0;
                        r_state    <= c_ST_DATA;
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_ack     <= 4'd0;
                        r_state   <= c_ST_TURN;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    // A beat always beats the watchdog, including on the last beat.
                    if (w_is_beat) begin
                        r_wd_cnt <= '0;
                        if (w_last_beat) begin
                            r_ack   <= 4'd0;
                            r_state <= c_ST_TURN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end else if (w_wd_expired) begin
                        r_timeout <= 1'b1;
                        r_ack     <= 4'd0;
                        r_state   <= c_ST_TURN;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                c_ST_TURN: begin
                    r_ack   <= 4'd0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_ack   <= 4'd0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != c_ST_IDLE);
    assign timeout  = r_timeout;

    a_ack_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(r_ack));

endmodule
`default_nettype wire

// File: tb/tb_bus_arb4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arb4
//  Description : Directed self-checking bench for bus_arb4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arb4;

    localparam int c_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] len;
    logic [2:0] bus_cmd;
    logic [3:0] ack;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int n_asserts = 0;
    int n_fail    = 0;

    bus_arb4 #(.TIMEOUT(c_TIMEOUT)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .len      (len),
        .bus_cmd  (bus_cmd),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 8'd0;
        len     = 8'd0;
        bus_cmd = 3'b000;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0] rr_order [5];
        rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset values
        do_reset();
        chk_val("rst_ack", ack, 4'b0000);
        chk_val("rst_gid", grant_id, 2'd0);
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_tmo", timeout, 1'b0);

        // 1: single master, 4-beat burst
        req = 8'b0000_0001; len = 8'b0000_0010;
        tick();
        chk_val("t1_ack", ack, 4'b0001);
        chk_val("t1_busy", busy, 1'b1);
        req = 8'd0; bus_cmd = 3'b100;
        tick();
        bus_cmd = 3'b001;
        tick(3);
        chk_val("t1_ack_b3", ack, 4'b0001);
        tick();
        chk_val("t1_ack_b4", ack, 4'b0000);
        chk_val("t1_turn_busy", busy, 1'b1);
        bus_cmd = 3'b000;
        tick();
        chk_val("t1_idle_busy", busy, 1'b0);
        chk_val("t1_gid_hold", grant_id, 2'd0);

        // 2: round-robin at equal priority
        do_reset();
        req = 8'b0101_0101; len = 8'd0;
        for (int g = 0; g < 5; g++) begin
            bus_cmd = 3'b000;
            tick();
            chk_val("t2_ack", ack, 4'b0001 << rr_order[g]);
            chk_val("t2_gid", grant_id, rr_order[g]);
            bus_cmd = 3'b010;
            tick();
            bus_cmd = 3'b011;
            tick();
            chk_val("t2_turn_ack", ack, 4'b0000);
            chk_val("t2_turn_busy", busy, 1'b1);
            bus_cmd = 3'b000;
            tick();
            chk_val("t2_idle_busy", busy, 1'b0);
        end

        // 3: priority, then rr within the lower level, no preemption
        do_reset();
        req = 8'b0011_0001; len = 8'd0;
        tick();
        chk_val("t3_hi_ack", ack, 4'b0100);
        chk_val("t3_hi_gid", grant_id, 2'd2);
        req = 8'b0001_0001; bus_cmd = 3'b010;
        tick();
        bus_cmd = 3'b011;
        tick();
        bus_cmd = 3'b000;
        tick(2);
        chk_val("t3_lo_ack", ack, 4'b0001);
        req = 8'b1100_0000;
        bus_cmd = 3'b010;
        tick();
        chk_val("t3_no_preempt", ack, 4'b0001);
        bus_cmd = 3'b011;
        tick();
        req = 8'd0; bus_cmd = 3'b000;
        tick(2);

        // 4: watchdog in GRANT, pending M3 follows two cycles later
        do_reset();
        req = 8'b0100_0100; len = 8'd0;
        tick();
        chk_val("t4_ack_m1", ack, 4'b0010);
        for (int i = 0; i < c_TIMEOUT - 1; i++) begin
            tick();
            chk_val("t4_hold_ack", ack, 4'b0010);
            chk_val("t4_hold_tmo", timeout, 1'b0);
        end
        tick();
        chk_val("t4_tmo", timeout, 1'b1);
        chk_val("t4_tmo_ack", ack, 4'b0000);
        tick();
        chk_val("t4_tmo_clear", timeout, 1'b0);
        req = 8'b0100_0000;
        tick();
        chk_val("t4_ack_m3", ack, 4'b1000);
        chk_val("t4_gid_m3", grant_id, 2'd3);
        req = 8'd0; bus_cmd = 3'b010;
        tick();
        bus_cmd = 3'b011;
        tick();
        bus_cmd = 3'b000;
        tick(2);

        // 5a: stall after 3 of 8 beats
        do_reset();
        req = 8'b0000_0001; len = 8'b0000_0011;
        tick();
        req = 8'd0; bus_cmd = 3'b100;
        tick();
        bus_cmd = 3'b001;
        tick(3);
        bus_cmd = 3'b000;
        tick(c_TIMEOUT - 1);
        chk_val("t5a_hold_ack", ack, 4'b0001);
        chk_val("t5a_hold_tmo", timeout, 1'b0);
        tick();
        chk_val("t5a_tmo", timeout, 1'b1);
        chk_val("t5a_ack", ack, 4'b0000);
        tick();

        // 5b: a beat in the last watchdog cycle keeps the burst alive
        req = 8'b0000_0001;
        tick();
        chk_val("t5b_ack", ack, 4'b0001);
        req = 8'd0; bus_cmd = 3'b100;
        tick();
        bus_cmd = 3'b001;
        tick(4);
        bus_cmd = 3'b000;
        tick(c_TIMEOUT - 1);
        bus_cmd = 3'b001;
        tick();
        chk_val("t5b_b5_tmo", timeout, 1'b0);
        chk_val("t5b_b5_ack", ack, 4'b0001);
        tick(2);
        chk_val("t5b_b7_ack", ack, 4'b0001);
        tick();
        chk_val("t5b_b8_ack", ack, 4'b0000);
        chk_val("t5b_b8_tmo", timeout, 1'b0);
        chk_val("t5b_b8_busy", busy, 1'b1);
        bus_cmd = 3'b000;
        tick();

        // 6: reset mid-burst, arbitration restarts at M0
        req = 8'b0001_0000; len = 8'b0010_0000;
        tick();
        chk_val("t6_ack_m2", ack, 4'b0100);
        req = 8'd0; bus_cmd = 3'b100;
        tick();
        bus_cmd = 3'b001;
        tick();
        reset = 1'b1;
        tick();
        chk_val("t6_rst_ack", ack, 4'b0000);
        chk_val("t6_rst_busy", busy, 1'b0);
        chk_val("t6_rst_gid", grant_id, 2'd0);
        reset = 1'b0; bus_cmd = 3'b000; req = 8'b0101_0101; len = 8'd0;
        tick();
        chk_val("t6_restart_ack", ack, 4'b0001);
        chk_val("t6_restart_gid", grant_id, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
